rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
Round-robin arbiter that shares one resource among 8 requesters and produces a one-hot grant vector.
- Holds a registered 3-bit grant index.
- A 3-to-8 one-hot decode stage with an active-low enable expands the index into the grant vector.
- A rotating priority pointer gives fair service.
- A hold-cycle limit stops any requester from keeping the resource indefinitely.
- Sits between 8 client request lines and the shared resource's select/enable inputs.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per tenure; legal range 1..255.
CNT_W, 8, width of hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  reset.
req  input  8  request lines, bit i = requester i; level-sensitive, held until served.
release_i  input  1  current grantee finished; sampled only in GRANT.
gnt  output  8  one-hot grant vector, all-zero when no grant.
gnt_idx  output  3  index of current grantee; valid only when gnt_valid=1.
gnt_valid  output  1  a grant is active.
timeout  output  1  one-cycle pulse when a tenure is cut by MAX_HOLD.

Interface decision:
- One clock; reset is synchronous and active-low.
- clk is the clock; rst_n is the reset.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - state=IDLE, ptr=0, gnt_idx=0, hold_cnt=0.
  - gnt_valid=0, gnt=8'h00, timeout=0.
  - Reset mid-grant drops the grant at that same edge; no timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, winner = first set bit searching ptr, ptr+1, ... wrapping 7->0.
  - At the next edge: gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency is one cycle from req asserted (in IDLE) to gnt asserted.
  - If req==0, remain in IDLE with outputs at reset values except ptr.
- GRANT, each cycle, evaluated in priority order:
  1. release_i=1 or req[gnt_idx]=0 -> end tenure, timeout stays 0.
  2. Else if hold_cnt==MAX_HOLD-1 -> end tenure, timeout=1 for the cycle following that edge.
  3. Else hold_cnt+=1, stay in GRANT.
- End of tenure, at the edge:
  - gnt_valid=0, ptr=(gnt_idx+1) mod 8 (3-bit natural wrap), state=IDLE.
  - There is exactly one dead cycle with gnt=0 between consecutive tenures, even when other requests are pending. This is required for resource turnaround.
- release_i and timeout condition in the same cycle: release wins, no timeout pulse.
- release_i asserted in IDLE: ignored.
- Grant vector:
  - gnt = one-hot decode of gnt_idx.
  - The decoder enable is driven active-low from ~gnt_valid, so gnt=0 whenever gnt_valid=0.
  - gnt is combinational from registers only; no input-to-output combinational path.
- Invariant: popcount(gnt) <= 1 on every cycle.
- Fairness: with all 8 requests held continuously, grants go 0,1,...,7,0 and each requester is served once per 8 tenures.
- Width rules:
  - hold_cnt is unsigned CNT_W bits and never exceeds MAX_HOLD-1.
  - ptr and gnt_idx are unsigned 3 bits with modulo-8 wrap.
- MAX_HOLD=1: every tenure lasts exactly one cycle and ends with timeout unless released or dropped that cycle.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=8, IDX_W=3.
  - State enum {IDLE, GRANT}.
  - Default MAX_HOLD constant.
- One sub-module, onehot_dec3_8:
  - Inputs: 3-bit index, active-low enable.
  - Output: 8-bit one-hot vector.
  - Purely combinational; instantiated once for gnt.
- Priority search (rotate-by-ptr, find-first-set, un-rotate) stays inline as a function.

Test Plan:
- Reset, then req=8'h04 held, release_i=0:
  - gnt=8'h04, gnt_idx=2 on the cycle after req rises.
  - timeout pulses after 16 grant cycles.
  - gnt=0 for one cycle, then gnt=8'h04 again.
- req=8'hFF held, release_i pulsed on the 3rd grant cycle of each tenure -> gnt_idx sequence 0,1,2,...,7,0, with one gnt=0 cycle between each tenure.
- ptr=7 (after serving 6), req=8'h41:
  - Next grant is idx 0 (wrap from 7), then idx 6.
- Grant to idx 3, deassert req[3] on the 2nd cycle without release_i -> tenure ends at that edge, timeout=0, ptr=4.
- MAX_HOLD=4, release_i=1 on the same cycle hold_cnt=3 -> tenure ends, timeout stays 0.
- rst_n=0 for one edge mid-grant (gnt=8'h20) -> next cycle gnt=0, gnt_valid=0, timeout=0; after release of reset with req=8'h21, the grant goes to idx 0 (ptr reset).

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Contents: requester count, index width, FSM state type and the
// default hold-cycle limit. Imported by the interface, decoder and top.
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the 8 clients and the arbiter.
// master : client side, drives req/release_i, observes the grant.
// slave  : arbiter side, observes requests, drives gnt/gnt_idx/gnt_valid/timeout.
interface rr_arbiter8_if;

  logic [arb_pkg::N_REQ-1:0] req;
  logic                      release_i;
  logic [arb_pkg::N_REQ-1:0] gnt;
  logic [arb_pkg::IDX_W-1:0] gnt_idx;
  logic                      gnt_valid;
  logic                      timeout;

  modport master (
    output req,
    output release_i,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  release_i,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface : rr_arbiter8_if

// File: rtl/rr_arbiter8_dec.sv
// 3-to-8 one-hot decoder with active-low enable (purely combinational).
// idx_i    : 3-bit index to decode
// en_n_i   : active-low enable; output is all-zero when high
// onehot_o : one-hot result
module onehot_dec3_8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_n_i,
  output logic [N_REQ-1:0] onehot_o
);

  // Decode index to one-hot, forced to zero while disabled
  always_comb begin
    onehot_o = 8'h00;
    if (!en_n_i) begin
      case (idx_i)
        3'd0:    onehot_o = 8'h01;
        3'd1:    onehot_o = 8'h02;
        3'd2:    onehot_o = 8'h04;
        3'd3:    onehot_o = 8'h08;
        3'd4:    onehot_o = 8'h10;
        3'd5:    onehot_o = 8'h20;
        3'd6:    onehot_o = 8'h40;
        3'd7:    onehot_o = 8'h80;
        default: onehot_o = 8'h00;
      endcase
    end else begin
      onehot_o = 8'h00;
    end
  end

endmodule : onehot_dec3_8

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with per-tenure hold limit.
// clk   : system clock, rising edge
// rst_n : synchronous active-low reset
// bus   : rr_arbiter8_if.slave (req, release_i in; gnt, gnt_idx,
//         gnt_valid, timeout out)
// A tenure ends on release, on the grantee dropping its request, or after
// MAX_HOLD grant cycles (timeout pulse). One dead cycle separates tenures.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter8_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W:0]   win_s;
  logic [N_REQ-1:0] gnt_s;

  // Returns {found, index}: rotate requests so ptr sits at bit 0, take the
  // lowest set bit, then add ptr back (3-bit wrap undoes the rotation).
  function automatic logic [IDX_W:0] find_winner(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic               found;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    off   = 3'd0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 3'(i);
      end
    end
    return {found, ptr + off};
  endfunction

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    win_s     = find_winner(bus.req, ptr_q);
    case (state_q)
      IDLE: begin
        if (win_s[IDX_W]) begin
          state_d = GRANT;
          idx_d   = win_s[IDX_W-1:0];
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          idx_d   = 3'd0;
          valid_d = 1'b0;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // Release/drop is checked first so it suppresses a same-cycle timeout
        if (bus.release_i || !bus.req[idx_q]) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
          idx_d   = 3'd0;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 3'd1;
          idx_d     = 3'd0;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        idx_d   = 3'd0;
        hold_d  = '0;
      end
    endcase
  end

  onehot_dec3_8 u_dec (
    .idx_i    (idx_q),
    .en_n_i   (~valid_q),
    .onehot_o (gnt_s)
  );

  // Outputs driven from registers only (no input-to-output path)
  always_comb begin
    bus.gnt       = gnt_s;
    bus.gnt_idx   = idx_q;
    bus.gnt_valid = valid_q;
    bus.timeout   = timeout_q;
  end

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  vec_t vecs[$];

  rr_arbiter8_if bus();
  rr_arbiter8_if bus4();

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic rl,
                              input logic [7:0] g, input logic [2:0] i,
                              input logic v, input logic t);
    vec_t x;
    x.rst_n = r; x.req = rq; x.rel = rl;
    x.gnt = g; x.idx = i; x.valid = v; x.to = t;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ag, input logic [2:0] ai,
                       input logic av, input logic at, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev, input logic et);
    logic ok;
    ok = (ag === eg) && (av === ev) && (at === et) && ($countones(ag) <= 1);
    if (ev) ok = ok && (ai === ei);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                  nm, ag, ai, av, at, eg, ei, ev, et);
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    bus.req = 8'h00; bus.release_i = 1'b0;
    bus4.req = 8'h00; bus4.release_i = 1'b0;
    step(); step();
    check("reset", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
          8'h00, 3'd0, 1'b0, 1'b0);
    if (bus.gnt_idx !== 3'd0) begin
      total_cnt++;
      $display("FAIL reset_idx: got %0d, want 0", bus.gnt_idx);
    end else begin
      total_cnt++; pass_cnt++;
    end

    // Single requester held: 16 grant cycles, timeout, dead cycle, regrant
    rst_n = 1'b1; bus.req = 8'h04;
    step();
    check("first_grant", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
          8'h04, 3'd2, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      step();
      check("hold", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
            8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    check("timeout_pulse", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
          8'h00, 3'd0, 1'b0, 1'b1);
    step();
    check("regrant", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
          8'h04, 3'd2, 1'b1, 1'b0);
    bus.req = 8'h00;
    step();
    check("drop_idle", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
          8'h00, 3'd0, 1'b0, 1'b0);

    // Vector table: each row's inputs are applied, one edge, then outputs checked
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h01 << k, 3'(k), 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h01 << k, 3'(k), 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h01 << k, 3'(k), 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    end
    vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    // ptr wrap from 7
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h40, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    // grantee 3 drops its request on 2nd cycle
    vecs.push_back(mk(1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h18, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h18, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h18, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    // reset mid-grant
    vecs.push_back(mk(1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    // release in IDLE is ignored
    vecs.push_back(mk(1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));

    foreach (vecs[n]) begin
      rst_n = vecs[n].rst_n; bus.req = vecs[n].req; bus.release_i = vecs[n].rel;
      step();
      check($sformatf("vec%0d", n), bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
            vecs[n].gnt, vecs[n].idx, vecs[n].valid, vecs[n].to);
    end
    bus.req = 8'h00; bus.release_i = 1'b0;

    // MAX_HOLD=4: release on the last hold cycle beats the timeout
    rst4_n = 1'b1; bus4.req = 8'h02;
    for (int c = 0; c < 4; c++) begin
      step();
      check("mh4_hold", bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.timeout,
            8'h02, 3'd1, 1'b1, 1'b0);
    end
    bus4.release_i = 1'b1;
    step();
    check("mh4_rel_wins", bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.timeout,
          8'h00, 3'd0, 1'b0, 1'b0);
    bus4.release_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("mh4_hold2", bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.timeout,
            8'h02, 3'd1, 1'b1, 1'b0);
    end
    step();
    check("mh4_timeout", bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.timeout,
          8'h00, 3'd0, 1'b0, 1'b1);
    bus4.req = 8'h00;
    step();
    check("mh4_pulse_end", bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.timeout,
          8'h00, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_rr_arbiter8
